// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier.
// Holds the FSM state encoding and the step-counter width.
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/sub M, then arithmetic shift of {A,Q,Q-1}.
// Operates on N-bit extended operands.
module booth_step #(
  parameter int N = 9
) (
  input  logic [2*N:0] aqq,
  input  logic [N-1:0] m,
  output logic [2*N:0] aqq_nx
);

  logic [N-1:0] a;
  logic [N-1:0] q;
  logic         qm1;
  logic [N:0]   a_x;
  logic [N:0]   m_x;
  logic [N:0]   sum;

  // One guard bit keeps A+/-M exact before the shift drops it again.
  always_comb begin
    a   = aqq[2*N:N+1];
    q   = aqq[N:1];
    qm1 = aqq[0];
    a_x = {a[N-1], a};
    m_x = {m[N-1], m};
    sum = a_x;
    unique case ({q[0], qm1})
      2'b01:   sum = a_x + m_x;
      2'b10:   sum = a_x - m_x;
      default: sum = a_x;
    endcase
    aqq_nx = {sum, q};
  end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 steps per product.
// Signed or unsigned operands selected per request.
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   M_in,
  input  logic [WIDTH-1:0]   Q_in,
  output logic [2*WIDTH-1:0] P,
  output logic               done,
  output logic               busy
);

  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_w(WIDTH);

  state_t        state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  m_r;
  logic          qm1_r;
  logic [CW-1:0] cnt;
  logic [N-1:0]  m_ext;
  logic [N-1:0]  q_ext;
  logic [2*N:0]  aqq_nx;

  always_comb begin
    m_ext = {signed_mode & M_in[WIDTH-1], M_in};
    q_ext = {signed_mode & Q_in[WIDTH-1], Q_in};
  end

  booth_step #(
    .N(N)
  ) u_step (
    .aqq   ({a_r, q_r, qm1_r}),
    .m     (m_r),
    .aqq_nx(aqq_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      qm1_r <= 1'b0;
      cnt   <= '0;
      P     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            m_r   <= m_ext;
            q_r   <= q_ext;
            a_r   <= '0;
            qm1_r <= 1'b0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          {a_r, q_r, qm1_r} <= aqq_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            P     <= aqq_nx[2*WIDTH:1];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands; sampled with start.
REQ-006 Port: M_in  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port: Q_in  input  WIDTH  multiplier; sampled with start.
REQ-008 Port: P  output  2*WIDTH  registered product, held until the next result.
REQ-009 Port: done  output  1  single-cycle pulse marking a new valid P.
REQ-010 Port: busy  output  1  high while a multiply is in progress.

Function
REQ-011 The block SHALL implement radix-2 Booth multiplication, one add/subtract plus arithmetic right shift per cycle.
REQ-012 States SHALL be IDLE and CALC only; reset enters IDLE.
REQ-013 In IDLE, start=1 at a rising edge SHALL latch M_in, Q_in and signed_mode, clear the accumulator and Booth bit Q(-1), load the step counter with WIDTH+1, and enter CALC.
REQ-014 Operands SHALL be extended to WIDTH+1 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-015 CALC SHALL perform exactly WIDTH+1 Booth steps, one per clock edge, using pair {Q[0],Q(-1)}:
- 01 = add M
- 10 = subtract M
- 00/11 = no operation
Each step SHALL be followed by an arithmetic shift right of {A,Q,Q(-1)}.
REQ-016 On the edge completing the final step, the block SHALL:
- load P with the low 2*WIDTH bits of the extended product
- set done=1 for exactly one cycle
- clear busy
- return to IDLE
REQ-017 Latency: done SHALL be high in the cycle following the (WIDTH+1)th edge after the start-sampling edge (WIDTH=8: 9 edges).
REQ-018 busy SHALL be 1 from the edge after start is sampled through the final CALC cycle, and 0 whenever done=1.
REQ-019 start asserted while busy=1 SHALL be ignored, with no effect on the current operation or on latched operands.
REQ-020 start held high continuously SHALL begin a new operation on the edge after done (done and the new start sample coincide in IDLE).
REQ-021 Input changes during CALC SHALL NOT affect the result.
REQ-022 P SHALL retain its value through IDLE and CALC; it SHALL change only at result load or reset.
REQ-023 Results SHALL be exact for all operand values in both modes, including:
- signed most-negative x most-negative
- unsigned all-ones x all-ones

Reset
REQ-024 Asserting rst low SHALL immediately force state=IDLE, P=0, done=0, busy=0, accumulator, Q register, Q(-1) and counter to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-026 After reset release, the first start SHALL be accepted no earlier than the first rising edge with rst high.

Structure
REQ-027 Shared package booth_pkg SHALL hold:
- the state encoding (IDLE, CALC)
- the counter-width function, clog2(WIDTH+2)
REQ-028 One sub-module, booth_step, SHALL be purely combinational: it takes {A,Q,Q(-1)} and M and returns the next {A,Q,Q(-1)} after add/sub and arithmetic shift, parametrised by WIDTH+1.
REQ-029 The top module SHALL contain only the FSM, counter and registers.

Verification (WIDTH=8 unless stated)
REQ-030 Unsigned: 10 x 20, then 255 x 1 -> P=200, then P=255; done is a 1-cycle pulse 9 edges after start is sampled.
REQ-031 Signed: -128 x -128 -> P=0x4000; 127 x -1 -> P=0xFF81; -1 x -1 -> P=0x0001.
REQ-032 start pulsed at cycle 3 of CALC with new operands -> ignored; first result unchanged, exactly one done.
REQ-033 rst driven low at CALC cycle 4 -> P=0, busy=0 immediately, no done; a subsequent 15 x 100 -> P=1500.
REQ-034 WIDTH=16 unsigned 65535 x 65535 -> P=0xFFFE0001; signed -32768 x 32767 -> P=0xC0008000.
REQ-035 Random sweep: 1000 random operand/mode pairs per WIDTH in {4,8,16} -> every P matches the reference product and busy/done timing matches REQ-017/REQ-018.
